// File: rtl/dec_2_92_batch32_pkg.sv
// rtl/dec_2_92_batch32_pkg.sv - shared types, constants and helpers for the batched decoder
package dec_2_92_batch32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_BITSIZE = 16;
    // Signed Qm.n words: the fraction takes half the word at the default size.
    localparam int FRAC_BITS   = DEF_BITSIZE / 2;
    localparam logic [DEF_BITSIZE-1:0] ONE = DEF_BITSIZE'(1) << FRAC_BITS;

    function automatic int batch_count(input int out_size, input int batch);
        return (out_size + batch - 1) / batch;
    endfunction

endpackage

// File: rtl/fixed_point_multiply.sv
// rtl/fixed_point_multiply.sv - signed fixed-point multiply, result truncated back to one word
// Ports: A, B - signed fixed-point operands; C - (A*B) >>> FRAC, low BITSIZE bits kept.
module fixed_point_multiply #(
    parameter int BITSIZE = 16,
    parameter int FRAC    = 8
) (
    input  logic [BITSIZE-1:0] A,
    input  logic [BITSIZE-1:0] B,
    output logic [BITSIZE-1:0] C
);
    logic signed [2*BITSIZE-1:0] full;

    assign full = $signed(A) * $signed(B);
    // Dropping the low FRAC bits of the double-width product is an arithmetic
    // shift; the upper bits are discarded so the result wraps like the adders.
    assign C = full[FRAC+BITSIZE-1:FRAC];

endmodule

// File: rtl/dec_2_92_batch32.sv
// rtl/dec_2_92_batch32.sv - affine decoder y = b + W*z computed BATCH outputs per cycle
// Ports: clk, reset (sync, active high); start request; z latent vector;
//        w weights and b bias (stable while busy); y registered outputs;
//        busy (RUN/DRAIN); done_all (DONE, every y word valid).
module dec_2_92_batch32
    import dec_2_92_batch32_pkg::*;
#(
    parameter int BITSIZE  = DEF_BITSIZE,
    parameter int IN_SIZE  = 2,
    parameter int OUT_SIZE = 92,
    parameter int BATCH    = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [BITSIZE*IN_SIZE-1:0]     z,
    input  logic [BITSIZE*OUT_SIZE*IN_SIZE-1:0] w,
    input  logic [BITSIZE*OUT_SIZE-1:0]    b,
    output logic [BITSIZE*OUT_SIZE-1:0]    y,
    output logic                           busy,
    output logic                           done_all
);
    localparam int BC    = batch_count(OUT_SIZE, BATCH);
    localparam int IDX_W = $clog2(BC + 1);
    localparam int LANES = BATCH * IN_SIZE;

    state_t state, next_state;
    logic [IDX_W-1:0]   batch_idx;
    logic [IDX_W-1:0]   s2_batch;
    logic               accept, last_batch, stage2_en;
    logic [BITSIZE-1:0] z_lat  [IN_SIZE];
    logic [BITSIZE-1:0] w_sel  [LANES];
    logic [BITSIZE-1:0] prod_d [LANES];
    logic [BITSIZE-1:0] prod_q [LANES];
    logic [BITSIZE-1:0] sum_d  [BATCH];
    logic [BITSIZE-1:0] y_mem  [OUT_SIZE];

    assign accept     = start && (state == ST_IDLE || state == ST_DONE);
    assign last_batch = (batch_idx == IDX_W'(BC - 1));
    // Stage 2 trails stage 1 by one edge, so it always works on batch_idx-1;
    // in DRAIN batch_idx has already stepped past the last batch.
    assign s2_batch   = batch_idx - IDX_W'(1);
    assign stage2_en  = (state == ST_RUN && batch_idx != '0) || state == ST_DRAIN;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // FSM: next state
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) next_state = ST_RUN;
            ST_RUN:           if (last_batch) next_state = ST_DRAIN;
            ST_DRAIN:         next_state = ST_DONE;
            default:          next_state = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy     = 1'b0;
        done_all = 1'b0;
        case (state)
            ST_RUN, ST_DRAIN: busy = 1'b1;
            ST_DONE:          done_all = 1'b1;
            default:          ;
        endcase
    end

    // Weight selection for the current stage-1 batch. The modulo keeps the
    // constant part-select in range for lanes that fall past OUT_SIZE; those
    // lanes are masked by the range test anyway.
    always_comb begin
        for (int l = 0; l < BATCH; l++) begin
            for (int i = 0; i < IN_SIZE; i++) begin
                w_sel[l*IN_SIZE+i] = '0;
                for (int k = 0; k < BC; k++) begin
                    if (32'(batch_idx) == 32'(k) && (k*BATCH + l) < OUT_SIZE)
                        w_sel[l*IN_SIZE+i] =
                            w[(((k*BATCH + l) % OUT_SIZE)*IN_SIZE + i)*BITSIZE +: BITSIZE];
                end
            end
        end
    end

    for (genvar l = 0; l < BATCH; l++) begin : g_lane
        for (genvar i = 0; i < IN_SIZE; i++) begin : g_in
            fixed_point_multiply #(
                .BITSIZE (BITSIZE),
                .FRAC    (FRAC_BITS)
            ) u_mul (
                .A (z_lat[i]),
                .B (w_sel[l*IN_SIZE+i]),
                .C (prod_d[l*IN_SIZE+i])
            );
        end
    end

    // Stage-2 sums: bias first, then products in ascending input order.
    always_comb begin
        for (int l = 0; l < BATCH; l++) begin
            sum_d[l] = '0;
            for (int k = 0; k < BC; k++) begin
                if (32'(s2_batch) == 32'(k) && (k*BATCH + l) < OUT_SIZE)
                    sum_d[l] = b[((k*BATCH + l) % OUT_SIZE)*BITSIZE +: BITSIZE];
            end
            for (int i = 0; i < IN_SIZE; i++)
                sum_d[l] = sum_d[l] + prod_q[l*IN_SIZE+i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            batch_idx <= '0;
            for (int i = 0; i < IN_SIZE; i++)  z_lat[i]  <= '0;
            for (int p = 0; p < LANES; p++)    prod_q[p] <= '0;
            for (int j = 0; j < OUT_SIZE; j++) y_mem[j]  <= '0;
        end else begin
            if (accept) begin
                batch_idx <= '0;
                for (int i = 0; i < IN_SIZE; i++)
                    z_lat[i] <= z[i*BITSIZE +: BITSIZE];
            end else if (state == ST_RUN) begin
                batch_idx <= batch_idx + IDX_W'(1);
            end

            if (state == ST_RUN) begin
                for (int l = 0; l < BATCH; l++)
                    for (int i = 0; i < IN_SIZE; i++)
                        prod_q[l*IN_SIZE+i] <= (int'(batch_idx)*BATCH + l < OUT_SIZE)
                                               ? prod_d[l*IN_SIZE+i] : '0;
            end

            // Only words that belong to the batch in stage 2 are written; the
            // rest keep their value, which also leaves padding lanes unused.
            if (stage2_en) begin
                for (int j = 0; j < OUT_SIZE; j++)
                    if (32'(j / BATCH) == 32'(s2_batch))
                        y_mem[j] <= sum_d[j % BATCH];
            end
        end
    end

    for (genvar j = 0; j < OUT_SIZE; j++) begin : g_y
        assign y[j*BITSIZE +: BITSIZE] = y_mem[j];
    end

endmodule

// File: doc/dec_2_92_batch32.md
DEC_2_92_BATCH32 -- requirements
Module: dec_2_92_batch32

Interface
REQ-001 Parameter BITSIZE, default 16, width of one fixed-point word.
REQ-002 Parameter IN_SIZE, default 2, number of latent input words.
REQ-003 Parameter OUT_SIZE, default 92, number of reconstructed output words.
REQ-004 Parameter BATCH, default 32, number of output words computed per cycle.
REQ-005 The block has one clock and a synchronous, active-high reset; ports SHALL be: clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 start  in  1  single-cycle request; accepted only in IDLE or DONE.
REQ-008 z  in  BITSIZE*IN_SIZE  latent vector; word i at z[i*BITSIZE +: BITSIZE].
REQ-009 w  in  BITSIZE*OUT_SIZE*IN_SIZE  weights; w(j,i) at [(j*IN_SIZE+i)*BITSIZE +: BITSIZE]; held stable while busy.
REQ-010 b  in  BITSIZE*OUT_SIZE  bias; word j at [j*BITSIZE +: BITSIZE]; held stable while busy.
REQ-011 y  out  BITSIZE*OUT_SIZE  registered outputs; word j at [j*BITSIZE +: BITSIZE].
REQ-012 busy  out  1  high in RUN and DRAIN.
REQ-013 done_all  out  1  high in DONE.

Function
REQ-014 Each output SHALL be y(j) = b(j) + sum over i of fxmul(z(i), w(j,i)), where fxmul is the shared fixed-point multiply.
REQ-015 Additions SHALL wrap modulo 2^BITSIZE, with no saturation; accumulation order is bias, then i ascending.
REQ-016 BATCH_COUNT = ceil(OUT_SIZE/BATCH), which is 3 at default parameters; batch k covers outputs k*BATCH .. min(k*BATCH+BATCH, OUT_SIZE)-1.
REQ-017 The FSM SHALL have four states: IDLE, RUN, DRAIN and DONE.
REQ-018 IDLE/DONE + start: latch z into an internal register, clear batch_idx, go to RUN, and drop done_all at the same edge.
REQ-019 Stage 1: in RUN, each edge registers BATCH x IN_SIZE products for batch_idx from the latched z; lanes with out-of-range output index register 0.
REQ-020 Stage 2: one edge after stage 1 of batch k, write y words of batch k with bias plus summed products; out-of-range lanes are never written.
REQ-021 RUN: batch_idx increments each edge; after stage 1 of the last batch, go to DRAIN.
REQ-022 DRAIN: perform stage 2 of the last batch, then go to DONE.
REQ-023 Latency at defaults: with start accepted at edge 0, y batch k is written at edge k+2 and done_all rises at edge 4; done_all SHALL equal 1 exactly when all OUT_SIZE words are valid.
REQ-024 DONE: y and done_all are held until reset or start.
REQ-025 start in RUN or DRAIN SHALL be ignored, with no restart and no queuing.
REQ-026 On a restart from DONE, y words SHALL keep their old values until overwritten by the new run.
REQ-027 Changes on z after acceptance SHALL not affect the current run.
REQ-028 reset and start in the same cycle: reset wins.

Reset
REQ-029 On reset: state=IDLE, batch_idx=0, latched z=0, product registers=0, y=0, busy=0, done_all=0.
REQ-030 Reset mid-run SHALL abort at that edge; partial y is cleared to 0 and start is accepted on the next cycle.

Structure
REQ-031 A shared package SHALL hold: the FSM state enum, the BITSIZE default, the fixed-point constant ONE (1.0), and the BATCH_COUNT function.
REQ-032 fixed_point_multiply (ports A, B, C) SHALL be the only sub-module, instantiated BATCH*IN_SIZE times.
REQ-033 There is no combinational path from start, z, w or b to y, busy or done_all.

Verification
REQ-034 Bench case 1: z=0, b(j)=j, single start -> done_all rises 4 cycles after start and y(j)=j for all 92 words.
REQ-035 Bench case 2: z={ONE,0}, w(j,0)=j+1, w(j,1)=0x7FFF, b=0 -> y(j)=j+1; lanes 92..95 leave no side effect.
REQ-036 Bench case 3: z={ONE,ONE}, w(j,0)=0xFFFF, w(j,1)=0x0002, b(j)=0x7FFF -> y(j)=0x8000, showing wrap.
REQ-037 Bench case 4: start repeated every cycle while busy -> exactly one run; done_all pulse timing matches the single-start case; z changed after acceptance leaves y unchanged.
REQ-038 Bench case 5: reset asserted at edge 2 of a run -> y=0, busy=0, done_all=0 next cycle; a later start completes correctly.
REQ-039 Bench case 6: back-to-back runs (start in DONE) -> done_all low for 4 cycles, then y equals the second run's golden values.
